// File: rtl/pad_resize_stream.sv
// pad_resize_stream: valid/ready width converter (zero/sign extend, unsigned/
// signed saturate) with a 2-entry output buffer holding converted beats.
// Optional lost-beat statistics counter: define PAD_RESIZE_STATS_EN.
module pad_resize_stream #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_lost
`ifdef PAD_RESIZE_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] stat_count
`endif
);

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_SIGN  = 2'd1,
    MODE_SAT_U = 2'd2,
    MODE_SAT_S = 2'd3
  } mode_t;

  mode_t                mode;
  logic [OUT_WIDTH-1:0] conv_data;
  logic                 conv_lost;

  assign mode = mode_t'(in_mode);

  if (OUT_WIDTH > IN_WIDTH) begin : g_widen
    localparam int EXT = OUT_WIDTH - IN_WIDTH;
    // Widening never loses information; signed modes replicate the MSB.
    always_comb begin
      conv_lost = 1'b0;
      if (mode == MODE_SIGN || mode == MODE_SAT_S)
        conv_data = {{EXT{in_data[IN_WIDTH-1]}}, in_data};
      else
        conv_data = {{EXT{1'b0}}, in_data};
    end
  end else if (OUT_WIDTH == IN_WIDTH) begin : g_equal
    // Equal widths pass straight through in every mode.
    always_comb begin
      conv_data = in_data;
      conv_lost = 1'b0;
      case (mode)
        MODE_ZERO, MODE_SIGN, MODE_SAT_U, MODE_SAT_S: begin
          conv_data = in_data;
          conv_lost = 1'b0;
        end
        default: ;
      endcase
    end
  end else begin : g_narrow
    localparam int DROP = IN_WIDTH - OUT_WIDTH;
    logic [DROP-1:0]      dropped;
    logic [DROP:0]        top;
    logic                 sign;
    logic [OUT_WIDTH-1:0] low;
    logic [OUT_WIDTH-1:0] sat_s_val;

    assign dropped = in_data[IN_WIDTH-1:OUT_WIDTH];
    assign top     = in_data[IN_WIDTH-1:OUT_WIDTH-1];
    assign sign    = in_data[IN_WIDTH-1];
    assign low     = in_data[OUT_WIDTH-1:0];

    // Signed clamp value: most negative when input negative, else most positive.
    always_comb begin
      sat_s_val                = {OUT_WIDTH{~sign}};
      sat_s_val[OUT_WIDTH-1]   = sign;
    end

    // Narrowing: truncate or clamp, flagging any numeric change.
    always_comb begin
      conv_data = low;
      conv_lost = 1'b0;
      case (mode)
        MODE_ZERO: conv_lost = |dropped;
        MODE_SIGN: conv_lost = (dropped != {DROP{in_data[OUT_WIDTH-1]}});
        MODE_SAT_U: begin
          if (|dropped) begin
            conv_data = '1;
            conv_lost = 1'b1;
          end
        end
        MODE_SAT_S: begin
          if (top != {(DROP+1){sign}}) begin
            conv_data = sat_s_val;
            conv_lost = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [OUT_WIDTH:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               push;
  logic               pop;

  assign in_ready  = resetn && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_lost, out_data} = mem[rd_ptr];

  // Two-entry circular buffer of converted {lost, data} beats.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= {conv_lost, conv_data};
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + 2'(push) - 2'(pop);
    end
  end

`ifdef PAD_RESIZE_STATS_EN
  // Saturating count of accepted beats that lost information; clear wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      stat_count <= '0;
    else if (stat_clear)
      stat_count <= '0;
    else if (push && conv_lost && !(&stat_count))
      stat_count <= stat_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pad_resize_stream.sv
// Bench for pad_resize_stream: five width configurations driven in lockstep,
// checked against a numeric reference model of the conversion rules.
module tb_pad_resize_stream;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        out_ready;
  logic [11:0] r;
  logic [1:0]  mode;
  logic        stat_clear;

  always #5 clock = ~clock;

  logic [11:0] o0;
  logic [7:0]  o1;
  logic [7:0]  o2;
  logic        o3;
  logic [7:0]  o4;
  logic        ir [5];
  logic        ov [5];
  logic        ol [5];
  logic [11:0] od [5];

  assign od[0] = o0;
  assign od[1] = 12'(o1);
  assign od[2] = 12'(o2);
  assign od[3] = 12'(o3);
  assign od[4] = 12'(o4);

  pad_resize_stream #(.IN_WIDTH(8), .OUT_WIDTH(12)) u0 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(r[7:0]), .in_mode(mode), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(o0), .out_lost(ol[0]));

`ifdef PAD_RESIZE_STATS_EN
  logic [1:0] stat1;
  pad_resize_stream #(.IN_WIDTH(12), .OUT_WIDTH(8), .STAT_WIDTH(2)) u1 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(r), .in_mode(mode), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(o1), .out_lost(ol[1]), .stat_clear(stat_clear), .stat_count(stat1));
`else
  pad_resize_stream #(.IN_WIDTH(12), .OUT_WIDTH(8)) u1 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(r), .in_mode(mode), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(o1), .out_lost(ol[1]));
`endif

  pad_resize_stream #(.IN_WIDTH(8), .OUT_WIDTH(8)) u2 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(r[7:0]), .in_mode(mode), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(o2), .out_lost(ol[2]));

  pad_resize_stream #(.IN_WIDTH(1), .OUT_WIDTH(1)) u3 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(r[0]), .in_mode(mode), .out_valid(ov[3]), .out_ready(out_ready),
    .out_data(o3), .out_lost(ol[3]));

  pad_resize_stream #(.IN_WIDTH(1), .OUT_WIDTH(8)) u4 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(ir[4]),
    .in_data(r[0]), .in_mode(mode), .out_valid(ov[4]), .out_ready(out_ready),
    .out_data(o4), .out_lost(ol[4]));

  typedef struct packed {
    logic [4:0][11:0] d;
    logic [4:0]       l;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        last_acc;
  logic        last_pop;
  logic [11:0] last_pop_d;

  function automatic int iwid(input int i);
    case (i)
      0: return 8;
      1: return 12;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int owid(input int i);
    case (i)
      0: return 12;
      3: return 1;
      default: return 8;
    endcase
  endfunction

  // Numeric model: interpret the input per mode, then wrap or clamp to OUT bits.
  function automatic void model(input logic [11:0] raw, input logic [1:0] m,
                                input int iw, input int ow,
                                output logic [11:0] res, output logic lost);
    longint uv, sv, mask, rv, rs, lim, c;
    mask = (longint'(1) << ow) - 1;
    uv   = longint'(raw) & ((longint'(1) << iw) - 1);
    sv   = (uv >= (longint'(1) << (iw - 1))) ? uv - (longint'(1) << iw) : uv;
    rv   = 0;
    lost = 1'b0;
    case (m)
      2'd0: begin rv = uv & mask; lost = (rv != uv); end
      2'd1: begin
        rv = sv & mask;
        rs = (rv >= (longint'(1) << (ow - 1))) ? rv - (longint'(1) << ow) : rv;
        lost = (rs != sv);
      end
      2'd2: begin rv = (uv > mask) ? mask : uv; lost = (rv != uv); end
      default: begin
        lim = longint'(1) << (ow - 1);
        c = sv;
        if (c > lim - 1) c = lim - 1;
        if (c < -lim) c = -lim;
        rv = c & mask;
        lost = (c != sv);
      end
    endcase
    res = 12'(rv);
  endfunction

  // One clock of stimulus; updates the reference queue from the handshakes.
  task automatic drive_cycle(input logic v, input logic [11:0] d,
                             input logic [1:0] m, input logic ordy);
    exp_t e;
    @(negedge clock);
    in_valid  = v;
    r         = d;
    mode      = m;
    out_ready = ordy;
    last_acc   = v && ir[0];
    last_pop   = ov[0] && ordy;
    last_pop_d = od[2];
    for (int i = 0; i < 5; i++) begin
      logic [11:0] rd;
      logic        rl;
      model(d, m, iwid(i), owid(i), rd, rl);
      e.d[i] = rd;
      e.l[i] = rl;
    end
    @(posedge clock);
    if (last_pop && q.size() > 0) void'(q.pop_front());
    if (last_acc) q.push_back(e);
    #1;
  endtask

  task automatic apply_reset();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    stat_clear = 1'b0;
    resetn     = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    q.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; stat_clear = 1'b0; r = '0; mode = '0;
    resetn = 1'b0;
    #12;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, ov[i]); end
      if (od[i] !== 12'h0) begin errors++; $display("FAIL reset_out_data[%0d]: got %h want 0", i, od[i]); end
      if (ol[i] !== 1'b0) begin errors++; $display("FAIL reset_out_lost[%0d]: got %b want 0", i, ol[i]); end
      if (ir[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, ir[i]); end
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin errors++; $display("FAIL release_in_ready[%0d]: got %b want 1", i, ir[i]); end
    end
    q.delete();
  endtask

  task automatic test_directed();
    apply_reset();
    drive_cycle(1'b1, 12'h080, 2'd1, 1'b1);
    checks += 3;
    if (ov[0] !== 1'b1) begin errors++; $display("FAIL widen_valid: got %b want 1", ov[0]); end
    if (od[0] !== 12'hF80) begin errors++; $display("FAIL widen_sign: got %h want f80", od[0]); end
    if (ol[0] !== 1'b0) begin errors++; $display("FAIL widen_sign_lost: got %b want 0", ol[0]); end
    drive_cycle(1'b1, 12'h080, 2'd0, 1'b1);
    checks++;
    if (od[0] !== 12'h080) begin errors++; $display("FAIL widen_zero: got %h want 080", od[0]); end
    drive_cycle(1'b1, 12'h001, 2'd1, 1'b1);
    checks += 2;
    if (od[4] !== 12'h0FF) begin errors++; $display("FAIL w1to8_sign: got %h want 0ff", od[4]); end
    if (od[3] !== 12'h001) begin errors++; $display("FAIL w1to1_pass: got %h want 001", od[3]); end
    drive_cycle(1'b1, 12'h7FF, 2'd3, 1'b1);
    checks += 2;
    if (od[1] !== 12'h07F) begin errors++; $display("FAIL sats_pos: got %h want 07f", od[1]); end
    if (ol[1] !== 1'b1) begin errors++; $display("FAIL sats_pos_lost: got %b want 1", ol[1]); end
    drive_cycle(1'b1, 12'h800, 2'd3, 1'b1);
    checks += 2;
    if (od[1] !== 12'h080) begin errors++; $display("FAIL sats_neg: got %h want 080", od[1]); end
    if (ol[1] !== 1'b1) begin errors++; $display("FAIL sats_neg_lost: got %b want 1", ol[1]); end
    drive_cycle(1'b1, 12'hFF0, 2'd3, 1'b1);
    checks += 2;
    if (od[1] !== 12'h0F0) begin errors++; $display("FAIL sats_fit: got %h want 0f0", od[1]); end
    if (ol[1] !== 1'b0) begin errors++; $display("FAIL sats_fit_lost: got %b want 0", ol[1]); end
    drive_cycle(1'b1, 12'h100, 2'd2, 1'b1);
    checks += 2;
    if (od[1] !== 12'h0FF) begin errors++; $display("FAIL satu: got %h want 0ff", od[1]); end
    if (ol[1] !== 1'b1) begin errors++; $display("FAIL satu_lost: got %b want 1", ol[1]); end
    drive_cycle(1'b0, 12'h000, 2'd0, 1'b1);
  endtask

  task automatic test_back_pressure();
    int k = 1;
    int got = 0;
    int cyc = 0;
    int first_pop = -1;
    int last_pop_cyc = -1;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 12'(k), 2'd0, 1'b0);
      if (last_acc) k++;
    end
    checks += 3;
    if (k !== 3) begin errors++; $display("FAIL bp_accepts: got %0d want 2", k - 1); end
    if (last_acc !== 1'b0) begin errors++; $display("FAIL bp_third_accept: got %b want 0", last_acc); end
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", ir[0]); end
    while (got < 5 && cyc < 20) begin
      drive_cycle(k <= 5, 12'(k), 2'd0, 1'b1);
      if (last_acc) k++;
      if (last_pop) begin
        checks++;
        if (last_pop_d !== 12'(got + 1)) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, last_pop_d, 12'(got + 1));
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop_cyc = cyc;
        got++;
      end
      cyc++;
    end
    checks += 3;
    if (got !== 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got); end
    if (last_pop_cyc - first_pop !== 4) begin
      errors++; $display("FAIL bp_throughput: got span %0d want 4", last_pop_cyc - first_pop);
    end
    drive_cycle(1'b0, 12'h0, 2'd0, 1'b1);
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", ov[0]); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive_cycle(1'b1, 12'h011, 2'd0, 1'b0);
    drive_cycle(1'b1, 12'h022, 2'd0, 1'b0);
    checks++;
    if (ir[0] !== 1'b0) begin errors++; $display("FAIL mr_full: got in_ready %b want 0", ir[0]); end
    @(negedge clock);
    in_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (ov[i] !== 1'b0) begin errors++; $display("FAIL mr_valid[%0d]: got %b want 0", i, ov[i]); end
      if (od[i] !== 12'h0) begin errors++; $display("FAIL mr_data[%0d]: got %h want 0", i, od[i]); end
      if (ir[i] !== 1'b0) begin errors++; $display("FAIL mr_ready[%0d]: got %b want 0", i, ir[i]); end
    end
    q.delete();
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks += 2;
    if (ir[0] !== 1'b1) begin errors++; $display("FAIL mr_release_ready: got %b want 1", ir[0]); end
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL mr_release_valid: got %b want 0", ov[0]); end
    drive_cycle(1'b0, 12'h0, 2'd0, 1'b1);
    drive_cycle(1'b0, 12'h0, 2'd0, 1'b1);
    checks++;
    if (ov[0] !== 1'b0) begin errors++; $display("FAIL mr_stale: got %b want 0", ov[0]); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, 12'($urandom), 2'($urandom),
                  $urandom_range(0, 2) != 0);
      for (int i = 0; i < 5; i++) begin
        checks += 2;
        if (ov[i] !== (q.size() != 0)) begin
          errors++; $display("FAIL rnd_valid[%0d] n=%0d: got %b want %b", i, n, ov[i], q.size() != 0);
        end
        if (ir[i] !== (q.size() < 2)) begin
          errors++; $display("FAIL rnd_ready[%0d] n=%0d: got %b want %b", i, n, ir[i], q.size() < 2);
        end
        if (q.size() != 0) begin
          checks += 2;
          if (od[i] !== q[0].d[i]) begin
            errors++; $display("FAIL rnd_data[%0d] n=%0d: got %h want %h", i, n, od[i], q[0].d[i]);
          end
          if (ol[i] !== q[0].l[i]) begin
            errors++; $display("FAIL rnd_lost[%0d] n=%0d: got %b want %b", i, n, ol[i], q[0].l[i]);
          end
        end
      end
    end
  endtask

`ifdef PAD_RESIZE_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++;
    if (stat1 !== 2'd0) begin errors++; $display("FAIL stat_reset: got %0d want 0", stat1); end
    drive_cycle(1'b1, 12'h0F0, 2'd2, 1'b1);
    checks++;
    if (stat1 !== 2'd0) begin errors++; $display("FAIL stat_no_loss: got %0d want 0", stat1); end
    repeat (2) drive_cycle(1'b1, 12'h100, 2'd2, 1'b1);
    checks++;
    if (stat1 !== 2'd2) begin errors++; $display("FAIL stat_two: got %0d want 2", stat1); end
    repeat (3) drive_cycle(1'b1, 12'h100, 2'd2, 1'b1);
    checks++;
    if (stat1 !== 2'd3) begin errors++; $display("FAIL stat_saturate: got %0d want 3", stat1); end
    stat_clear = 1'b1;
    drive_cycle(1'b1, 12'h100, 2'd2, 1'b1);
    stat_clear = 1'b0;
    checks++;
    if (stat1 !== 2'd0) begin errors++; $display("FAIL stat_clear_prio: got %0d want 0", stat1); end
    drive_cycle(1'b0, 12'h0, 2'd0, 1'b1);
    drive_cycle(1'b0, 12'h0, 2'd0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_mid_reset();
    test_random();
`ifdef PAD_RESIZE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pad_resize_stream.md
Name: pad_resize_stream

Overview:
- Streaming, parametrised width converter with a valid/ready handshake on both sides.
- Converts each beat from IN_WIDTH to OUT_WIDTH under a per-beat mode: zero-extend, sign-extend, unsigned saturate or signed saturate.
- Buffers up to two beats, so it sustains full throughput under back-pressure.
- Sits between datapath stages of differing precision, e.g. accumulator to posit/float encoder inputs.

Parameters:
- IN_WIDTH, 8, input beat width, >=1.
- OUT_WIDTH, 8, output beat width, >=1; may be less than, equal to or greater than IN_WIDTH.
- STAT_WIDTH, 16, width of the lost-information event counter (optional feature only).

Ports:
- clock  input  1  sole clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN_WIDTH  input beat.
- in_mode  input  2  0=ZERO, 1=SIGN, 2=SAT_U, 3=SAT_S; sampled with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_WIDTH  converted beat.
- out_lost  output  1  converted value differs numerically from the input under the mode's interpretation.
- stat_clear  input  1  synchronous clear of stat_count (optional feature only).
- stat_count  output  STAT_WIDTH  lost-beat count (optional feature only).

Behaviour:
- Reset (resetn low, asynchronous): buffer empty; out_valid=0; out_data=0; out_lost=0; in_ready=0 while resetn is low.
- After reset: in_ready=1 from the first cycle resetn is high.
- Handshake:
  - Transfer occurs when valid&&ready on a side.
  - out_valid, once high, holds with stable out_data and out_lost until out_ready.
  - in_ready does not depend combinationally on out_ready or in_valid.
- Buffer: 2-entry FIFO of {data, lost}, conversion performed before storage.
  - in_ready = (count<2).
  - out_valid = (count>0).
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Count 2: no push, since in_ready=0.
- Latency: beat accepted at edge N is on out_data after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle while out_ready=1.
- Conversion, widening (OUT>IN):
  - ZERO and SAT_U: zero-extend.
  - SIGN and SAT_S: replicate in_data[IN-1].
  - lost=0.
- Conversion, equal widths: pass-through in all modes; lost=0.
- Conversion, narrowing (OUT<IN):
  - ZERO and SIGN: keep low OUT bits. ZERO: lost = any dropped bit set. SIGN: lost = dropped bits not all equal to out bit OUT-1.
  - SAT_U: if any dropped bit set, out = all ones and lost=1; else low bits.
  - SAT_S: if dropped bits plus bit OUT-1 are not all equal to in sign, out = in sign ? {1,0...0} : {0,1...1} and lost=1; else low bits.
- All generate branches must elaborate with no zero-width fields for any IN/OUT combination, including OUT=1 or IN=1.

Optional Feature:
- Macro PAD_RESIZE_STATS_EN.
- Defined:
  - stat_clear/stat_count ports exist.
  - stat_count increments on every accepted input beat whose lost=1.
  - Saturates at all ones (no wrap).
  - stat_clear has priority over a same-cycle increment.
  - Resets to 0.
- Undefined: the ports are absent and no counter logic is present.

Test Plan:
- IN=8, OUT=12, mode SIGN, in_data=0x80 -> out_data=0xF80, lost=0, one cycle after accept. Mode ZERO, same input -> 0x080.
- IN=12, OUT=8:
  - SAT_S, in=0x7FF -> 0x7F, lost=1.
  - in=0x800 -> 0x80, lost=1.
  - in=0xFF0 -> 0xF0, lost=0.
  - SAT_U in=0x100 -> 0xFF, lost=1.
- Back-pressure: stream 0x01..0x05 with out_ready low for 3 cycles.
  - in_ready drops after 2 accepts.
  - Output order 0x01..0x05, no loss or duplication.
  - Sustained 1/cycle once out_ready returns high.
- Reset mid-stream with 2 beats buffered -> out_valid=0 immediately; no stale beat after release; in_ready=1 the first cycle resetn is high.
- IN=OUT=1 and IN=1, OUT=8 SIGN in=1 -> 0xFF; elaboration clean.
- With PAD_RESIZE_STATS_EN, STAT_WIDTH=2:
  - 5 lost beats -> stat_count 3 (saturates).
  - stat_clear coincident with a lost beat -> 0.
